updown_counter: RTL and testbench
=================================

# updown_counter

Runtime-controlled up/down counter for timing and sequencing logic: enable, direction, parallel load and wrap limit are inputs rather than fixed parameters. The count advances on a power-of-two prescaled tick. The block reports value changes and terminal-count wraps as single-cycle pulses. It supersedes the fixed-direction, fixed-top counter wherever direction or modulus must change at run time.

## Interface
- SIZE, 8, counter width in bits (≥1)
- DIV, 0, prescaler exponent; count advances once per 2^DIV enabled cycles (0 = every enabled cycle)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_en  in  1  count enable; prescaler and counter hold when low
- i_up  in  1  direction, 1 = up, 0 = down; sampled on each tick
- i_load  in  1  parallel load strobe
- i_load_value  in  SIZE  value loaded when i_load is high
- i_top  in  SIZE  wrap limit; counter range is 0..i_top
- value  out  SIZE  current count (registered)
- o_change  out  1  high for one cycle when value differs from the previous cycle
- o_wrap  out  1  high for one cycle when a terminal-count wrap occurred

## Operation
- Priority per edge: rst > i_load > tick > hold.
- Prescaler:
  - DIV-bit register, incremented on every cycle with i_en=1.
  - tick = i_en & (prescaler == all-ones). When DIV=0, tick = i_en.
  - Prescaler wraps naturally and holds its value while i_en=0.
- Up tick:
  - value ≥ i_top → value=0, o_wrap=1.
  - Otherwise value+1.
- Down tick:
  - value == 0 → value=i_top, o_wrap=1.
  - value > i_top → value=i_top, no wrap (clamp after i_top lowered).
  - Otherwise value−1.
- Load:
  - value=i_load_value, prescaler cleared to 0, o_wrap=0.
  - The loaded value may exceed i_top. The next up tick then wraps to 0 with o_wrap=1.
- i_top=0: every tick yields value 0; up ticks and down ticks both assert o_wrap.
- i_top = 2^SIZE−1: full-range modular counter.
- o_change = 1 iff the value register takes a different value at this edge, including load and clamp. A load of an identical value gives o_change=0.
- Arithmetic is unsigned SIZE-bit. Comparisons are unsigned.

## Timing
- Reset values: value=0, prescaler=0, o_change=0, o_wrap=0 (and o_capture=0 when enabled).
- rst asserted mid-count takes effect at the next edge and overrides a simultaneous i_load.
- value, o_change and o_wrap are all registered and update on the same edge. A pulse is visible in the same cycle as the new value it describes.
- Latency: input at edge N → value at N+1. First tick after reset/load with i_en held high occurs on the 2^DIV-th enabled edge.
- i_up and i_top are used combinationally in the update; changing them between ticks has no effect until the next tick.

## Configuration
- Macro UPDOWN_COUNTER_CAPTURE_EN.
- Defined:
  - Adds port i_capture (in, 1) and port o_capture (out, SIZE).
  - When i_capture=1, o_capture is loaded with the pre-edge value. When i_capture=1 coincides with a tick or load, it captures the old value.
  - o_capture holds otherwise and resets to 0.
- Undefined: both ports and the capture register are absent. All other behaviour is identical.

## Structure
- Shared package updown_counter_pkg holds:
  - direction constants DIR_UP=1, DIR_DOWN=0
  - a function computing the next count from (value, top, up), returning {wrap, next}. The bench's reference model reuses this function.
- One sub-module: clk_prescaler (parameter DIV; ports clk, rst, i_en, i_clear, o_tick).
  - For DIV=0 it degenerates to o_tick = i_en.

## Test plan
- Reset and run: SIZE=8, DIV=0, i_top=5, i_up=1, i_en=1 → value 0,1,2,3,4,5,0. o_wrap high only with value 0 after 5. o_change high every cycle.
- Down and prescale: DIV=2, i_top=3, i_up=0 → value changes every 4th cycle: 0→3 (o_wrap), 3→2→1→0→3. o_change high only on change cycles.
- Load above top: i_top=10; load 200 → value=200, o_change=1. Next up tick → 0 with o_wrap=1. Load 200 again, switch down → next tick → 10, o_wrap=0.
- Simultaneous events: i_load with tick pending → load wins, prescaler cleared. rst with i_load=1 → value=0, all outputs 0. Load of the current value → o_change=0.
- Enable hold: DIV=3, deassert i_en after 5 cycles for 10 cycles → value and prescaler frozen. The tick arrives 3 enabled cycles after re-enable.
- Capture (UPDOWN_COUNTER_CAPTURE_EN): i_capture pulsed on the tick edge 4→5 → o_capture=4. Without the macro, the build omits the ports and the other tests pass unchanged.

Source files
------------

// File: rtl/updown_counter_pkg.sv
// Shared definitions for the run-time controlled up/down counter.
// Holds the direction encoding and the next-count function. The counter
// and its reference model both use this function.
package updown_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Widest counter the step function supports. Callers zero-extend.
  localparam int CNT_W = 32;

  // Returns {wrap, next} for one tick in direction 'up' with limit 'top'.
  function automatic logic [CNT_W:0] next_count(input logic [CNT_W-1:0] value,
                                                input logic [CNT_W-1:0] top,
                                                input logic             up);
    logic [CNT_W:0] res;
    res = {1'b0, value};
    if (up == DIR_UP) begin
      if (value >= top) res = {1'b1, {CNT_W{1'b0}}};
      else              res = {1'b0, value + CNT_W'(1)};
    end else begin
      if (value == '0)       res = {1'b1, top};
      else if (value > top)  res = {1'b0, top};
      else                   res = {1'b0, value - CNT_W'(1)};
    end
    return res;
  endfunction

endpackage

// File: rtl/updown_counter_prescaler.sv
// Power-of-two prescaler: o_tick fires once every 2^DIV enabled cycles.
// i_clear restarts the count. With DIV=0 the output is simply i_en.
module clk_prescaler #(
  parameter int DIV = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clear,
  output logic o_tick
);

  if (DIV == 0) begin : g_passthru
    // No counter when DIV is zero, so clk, rst and i_clear go unused.
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, i_clear};
    assign o_tick = i_en;
  end else begin : g_count
    logic [DIV-1:0] cnt_q, cnt_d;

    // Next prescaler count: clear wins, then advance while enabled.
    always_comb begin
      cnt_d = cnt_q;
      if (i_clear)   cnt_d = '0;
      else if (i_en) cnt_d = cnt_q + DIV'(1);
    end

    // Prescaler register with synchronous reset.
    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign o_tick = i_en & (&cnt_q);
  end

endmodule

// File: rtl/updown_counter.sv
// Up/down counter with run-time enable, direction, load and wrap limit.
// Emits single-cycle o_change and o_wrap pulses alongside the new value.
// Optional capture register enabled by macro UPDOWN_COUNTER_CAPTURE_EN.
module updown_counter
  import updown_counter_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int DIV  = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic            i_up,
  input  logic            i_load,
  input  logic [SIZE-1:0] i_load_value,
  input  logic [SIZE-1:0] i_top,
  output logic [SIZE-1:0] value,
  output logic            o_change,
  output logic            o_wrap
`ifdef UPDOWN_COUNTER_CAPTURE_EN
  ,
  input  logic            i_capture,
  output logic [SIZE-1:0] o_capture
`endif
);

  logic            tick;
  logic [SIZE-1:0] value_q, value_d;
  logic            change_q, change_d;
  logic            wrap_q, wrap_d;
  logic [CNT_W:0]  step_res;

  // A load restarts the prescaler so the next tick is a full period away.
  clk_prescaler #(.DIV(DIV)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .i_en   (i_en),
    .i_clear(i_load),
    .o_tick (tick)
  );

  if (SIZE < CNT_W) begin : g_pad
    // Upper bits of the widened step result are always zero.
    logic unused_pad;
    assign unused_pad = ^step_res[CNT_W-1:SIZE];
  end

  // Next value: load beats tick; change flags any difference in the value.
  always_comb begin
    step_res = next_count(CNT_W'(value_q), CNT_W'(i_top), i_up);
    value_d  = value_q;
    wrap_d   = 1'b0;
    if (i_load) begin
      value_d = i_load_value;
    end else if (tick) begin
      value_d = step_res[SIZE-1:0];
      wrap_d  = step_res[CNT_W];
    end
    change_d = (value_d != value_q);
  end

  // Count and pulse registers, all updated on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q  <= '0;
      change_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      value_q  <= value_d;
      change_q <= change_d;
      wrap_q   <= wrap_d;
    end
  end

  assign value    = value_q;
  assign o_change = change_q;
  assign o_wrap   = wrap_q;

`ifdef UPDOWN_COUNTER_CAPTURE_EN
  logic [SIZE-1:0] capture_q, capture_d;

  // Snapshot of the value as it was before this edge.
  always_comb begin
    capture_d = capture_q;
    if (i_capture) capture_d = value_q;
  end

  // Capture register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) capture_q <= '0;
    else     capture_q <= capture_d;
  end

  assign o_capture = capture_q;
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter. Three instances share stimulus:
// u0 (DIV=0), u2 (DIV=2), u3 (DIV=3); each test checks the relevant one.
module tb_updown_counter;
  import updown_counter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up, load, capture;
  logic [7:0] lv, top;
  logic [7:0] val0, val2, val3;
  logic       chg0, chg2, chg3, wrp0, wrp2, wrp3;
`ifdef UPDOWN_COUNTER_CAPTURE_EN
  logic [7:0] cap0, cap2, cap3;
`endif

  int errors = 0;
  int checks = 0;

  updown_counter #(.SIZE(8), .DIV(0)) u0 (
    .clk(clk), .rst(rst), .i_en(en), .i_up(up), .i_load(load),
    .i_load_value(lv), .i_top(top), .value(val0), .o_change(chg0), .o_wrap(wrp0)
`ifdef UPDOWN_COUNTER_CAPTURE_EN
    , .i_capture(capture), .o_capture(cap0)
`endif
  );

  updown_counter #(.SIZE(8), .DIV(2)) u2 (
    .clk(clk), .rst(rst), .i_en(en), .i_up(up), .i_load(load),
    .i_load_value(lv), .i_top(top), .value(val2), .o_change(chg2), .o_wrap(wrp2)
`ifdef UPDOWN_COUNTER_CAPTURE_EN
    , .i_capture(capture), .o_capture(cap2)
`endif
  );

  updown_counter #(.SIZE(8), .DIV(3)) u3 (
    .clk(clk), .rst(rst), .i_en(en), .i_up(up), .i_load(load),
    .i_load_value(lv), .i_top(top), .value(val3), .o_change(chg3), .o_wrap(wrp3)
`ifdef UPDOWN_COUNTER_CAPTURE_EN
    , .i_capture(capture), .o_capture(cap3)
`endif
  );

  // One clock edge; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; en = 1'b0; capture = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; up = DIR_UP; load = 1'b1; lv = 8'd77; top = 8'd5; capture = 1'b0;
    step();
    checks++; if (val0 !== 8'd0) begin errors++; $display("[TB] FAIL reset_value got=%0d exp=0", val0); end
    checks++; if (chg0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_change got=%b exp=0", chg0); end
    checks++; if (wrp0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrap got=%b exp=0", wrp0); end
    checks++; if (val3 !== 8'd0) begin errors++; $display("[TB] FAIL reset_value_div3 got=%0d exp=0", val3); end
`ifdef UPDOWN_COUNTER_CAPTURE_EN
    checks++; if (cap0 !== 8'd0) begin errors++; $display("[TB] FAIL reset_capture got=%0d exp=0", cap0); end
`endif
  endtask

  task automatic test_run();
    logic [7:0] exp_v [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};
    rst = 1'b0; load = 1'b0; en = 1'b1; up = DIR_UP; top = 8'd5;
    for (int k = 0; k < 7; k++) begin
      capture = (k == 4);
      step();
      checks++; if (val0 !== exp_v[k]) begin errors++; $display("[TB] FAIL run_value[%0d] got=%0d exp=%0d", k, val0, exp_v[k]); end
      checks++; if (wrp0 !== (k == 5)) begin errors++; $display("[TB] FAIL run_wrap[%0d] got=%b exp=%b", k, wrp0, (k == 5)); end
      checks++; if (chg0 !== 1'b1) begin errors++; $display("[TB] FAIL run_change[%0d] got=%b exp=1", k, chg0); end
`ifdef UPDOWN_COUNTER_CAPTURE_EN
      if (k >= 4) begin
        checks++; if (cap0 !== 8'd4) begin errors++; $display("[TB] FAIL capture[%0d] got=%0d exp=4", k, cap0); end
      end
`endif
    end
    capture = 1'b0;
  endtask

  task automatic test_load_above_top();
    top = 8'd10; en = 1'b1; up = DIR_UP; load = 1'b1; lv = 8'd200;
    step();
    checks++; if (val0 !== 8'd200) begin errors++; $display("[TB] FAIL load_value got=%0d exp=200", val0); end
    checks++; if (chg0 !== 1'b1) begin errors++; $display("[TB] FAIL load_change got=%b exp=1", chg0); end
    checks++; if (wrp0 !== 1'b0) begin errors++; $display("[TB] FAIL load_wrap got=%b exp=0", wrp0); end
    load = 1'b0;
    step();
    checks++; if (val0 !== 8'd0) begin errors++; $display("[TB] FAIL above_up_value got=%0d exp=0", val0); end
    checks++; if (wrp0 !== 1'b1) begin errors++; $display("[TB] FAIL above_up_wrap got=%b exp=1", wrp0); end
    load = 1'b1;
    step();
    load = 1'b0; up = DIR_DOWN;
    step();
    checks++; if (val0 !== 8'd10) begin errors++; $display("[TB] FAIL clamp_value got=%0d exp=10", val0); end
    checks++; if (wrp0 !== 1'b0) begin errors++; $display("[TB] FAIL clamp_wrap got=%b exp=0", wrp0); end
    checks++; if (chg0 !== 1'b1) begin errors++; $display("[TB] FAIL clamp_change got=%b exp=1", chg0); end
  endtask

  task automatic test_top_zero();
    load = 1'b1; lv = 8'd0; en = 1'b1;
    step();
    load = 1'b0; top = 8'd0; up = DIR_UP;
    step();
    checks++; if (val0 !== 8'd0) begin errors++; $display("[TB] FAIL top0_up_value got=%0d exp=0", val0); end
    checks++; if (wrp0 !== 1'b1) begin errors++; $display("[TB] FAIL top0_up_wrap got=%b exp=1", wrp0); end
    checks++; if (chg0 !== 1'b0) begin errors++; $display("[TB] FAIL top0_up_change got=%b exp=0", chg0); end
    up = DIR_DOWN;
    step();
    checks++; if (val0 !== 8'd0) begin errors++; $display("[TB] FAIL top0_down_value got=%0d exp=0", val0); end
    checks++; if (wrp0 !== 1'b1) begin errors++; $display("[TB] FAIL top0_down_wrap got=%b exp=1", wrp0); end
  endtask

  task automatic test_full_range();
    top = 8'd255; load = 1'b1; lv = 8'd255; en = 1'b1;
    step();
    load = 1'b0; up = DIR_UP;
    step();
    checks++; if (val0 !== 8'd0) begin errors++; $display("[TB] FAIL full_up_value got=%0d exp=0", val0); end
    checks++; if (wrp0 !== 1'b1) begin errors++; $display("[TB] FAIL full_up_wrap got=%b exp=1", wrp0); end
    up = DIR_DOWN;
    step();
    checks++; if (val0 !== 8'd255) begin errors++; $display("[TB] FAIL full_down_value got=%0d exp=255", val0); end
    checks++; if (wrp0 !== 1'b1) begin errors++; $display("[TB] FAIL full_down_wrap got=%b exp=1", wrp0); end
  endtask

  task automatic test_down_prescale();
    logic [7:0] exp_v [20] = '{8'd0, 8'd0, 8'd0, 8'd3, 8'd3, 8'd3, 8'd3, 8'd2, 8'd2, 8'd2,
                               8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3};
    top = 8'd3; up = DIR_DOWN;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++; if (val2 !== exp_v[i]) begin errors++; $display("[TB] FAIL down_value[%0d] got=%0d exp=%0d", i, val2, exp_v[i]); end
      checks++; if (chg2 !== ((i % 4) == 3)) begin errors++; $display("[TB] FAIL down_change[%0d] got=%b exp=%b", i, chg2, ((i % 4) == 3)); end
      checks++; if (wrp2 !== (i == 3 || i == 19)) begin errors++; $display("[TB] FAIL down_wrap[%0d] got=%b exp=%b", i, wrp2, (i == 3 || i == 19)); end
    end
  endtask

  task automatic test_simultaneous();
    top = 8'd9; up = DIR_UP;
    do_reset();
    en = 1'b1;
    repeat (3) step();
    load = 1'b1; lv = 8'd7;
    step();
    checks++; if (val2 !== 8'd7) begin errors++; $display("[TB] FAIL load_vs_tick got=%0d exp=7", val2); end
    load = 1'b0;
    repeat (3) step();
    checks++; if (val2 !== 8'd7) begin errors++; $display("[TB] FAIL presc_cleared got=%0d exp=7", val2); end
    step();
    checks++; if (val2 !== 8'd8) begin errors++; $display("[TB] FAIL tick_after_load got=%0d exp=8", val2); end
    load = 1'b1; lv = 8'd8;
    step();
    checks++; if (chg2 !== 1'b0) begin errors++; $display("[TB] FAIL same_load_change got=%b exp=0", chg2); end
    checks++; if (val2 !== 8'd8) begin errors++; $display("[TB] FAIL same_load_value got=%0d exp=8", val2); end
    rst = 1'b1; lv = 8'd5;
    step();
    rst = 1'b0; load = 1'b0;
    checks++; if (val2 !== 8'd0) begin errors++; $display("[TB] FAIL rst_over_load got=%0d exp=0", val2); end
    checks++; if (chg2 !== 1'b0) begin errors++; $display("[TB] FAIL rst_change got=%b exp=0", chg2); end
    checks++; if (wrp2 !== 1'b0) begin errors++; $display("[TB] FAIL rst_wrap got=%b exp=0", wrp2); end
  endtask

  task automatic test_enable_hold();
    top = 8'd200; up = DIR_UP;
    do_reset();
    en = 1'b1;
    repeat (5) step();
    checks++; if (val3 !== 8'd0) begin errors++; $display("[TB] FAIL hold_pre got=%0d exp=0", val3); end
    en = 1'b0;
    repeat (10) step();
    checks++; if (val3 !== 8'd0) begin errors++; $display("[TB] FAIL hold_frozen got=%0d exp=0", val3); end
    checks++; if (chg3 !== 1'b0) begin errors++; $display("[TB] FAIL hold_change got=%b exp=0", chg3); end
    en = 1'b1;
    repeat (2) step();
    checks++; if (val3 !== 8'd0) begin errors++; $display("[TB] FAIL hold_early got=%0d exp=0", val3); end
    step();
    checks++; if (val3 !== 8'd1) begin errors++; $display("[TB] FAIL hold_tick got=%0d exp=1", val3); end
    checks++; if (chg3 !== 1'b1) begin errors++; $display("[TB] FAIL hold_tick_change got=%b exp=1", chg3); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_load_above_top();
    test_top_zero();
    test_full_range();
    test_down_prescale();
    test_simultaneous();
    test_enable_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
